// File: rtl/fpu_pkg.sv
// Shared F32 types, field limits and integer range constants for the FPU cluster.
package fpu_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } f32_t;

    localparam logic [7:0]  F32_BIAS    = 8'd127;
    localparam logic [7:0]  F32_EXP_MAX = 8'd255;

    localparam logic [31:0] INT32_MIN  = 32'h8000_0000;
    localparam logic [31:0] INT32_MAX  = 32'h7FFF_FFFF;
    localparam logic [31:0] UINT32_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        F32_NORMAL,
        F32_TINY,
        F32_INF,
        F32_NAN
    } f32_class_t;

endpackage

// File: rtl/fpu_f32_unpack.sv
// Combinational split of an F32 word into sign, exponent, mantissa with hidden bit,
// and a coarse class used by the integer conversion paths.
module fpu_f32_unpack
    import fpu_pkg::*;
(
    input  f32_t            a_i,
    output logic            sign_o,
    output logic [7:0]      exp_o,
    output logic [23:0]     mant_o,
    output f32_class_t      class_o
);

    assign sign_o = a_i.sign;
    assign exp_o  = a_i.exp;
    assign mant_o = {a_i.exp != 8'd0, a_i.frac};

    // TINY covers zero and denormals as well: all of them truncate to 0.
    always_comb begin
        class_o = F32_NORMAL;
        if (a_i.exp == F32_EXP_MAX) begin
            class_o = (a_i.frac != 23'd0) ? F32_NAN : F32_INF;
        end else if (a_i.exp < F32_BIAS) begin
            class_o = F32_TINY;
        end
    end

endmodule

// File: rtl/fpu_f32_to_int.sv
// Three-stage F32 to int32/uint32 converter (truncate toward zero) with valid/ready on both sides.
// Define FPU_F2I_SATURATE_EN to saturate invalid inputs instead of returning the indefinite value.
module fpu_f32_to_int
    import fpu_pkg::*;
#(
    parameter bit UNSIGNED = 1'b0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] A,
    input  logic        A_VALID,
    output logic        A_READY,
    output logic [31:0] O,
    output logic        O_INVALID,
    output logic        O_VALID,
    input  logic        O_READY
);

    // Exponent at which the mantissa LSB has weight 1, and the largest in-range exponents.
    localparam logic [7:0] EXP_LSB_ONE = 8'd150;
    localparam logic [7:0] EXP_S_MAX   = 8'd157;
    localparam logic [7:0] EXP_U_MAX   = 8'd158;

    logic        un_sign;
    logic [7:0]  un_exp;
    logic [23:0] un_mant;
    f32_class_t  un_class;

    fpu_f32_unpack u_unpack (
        .a_i     (f32_t'(A)),
        .sign_o  (un_sign),
        .exp_o   (un_exp),
        .mant_o  (un_mant),
        .class_o (un_class)
    );

    logic        v0_q, s0_q;
    logic [7:0]  e0_q;
    logic [23:0] m0_q;
    f32_class_t  cls0_q;

    logic        v1_q, s1_q, ok1_q;
    logic [31:0] mag1_q;
    f32_class_t  cls1_q;

    logic        v2_q, inv2_q;
    logic [31:0] res2_q;

    logic        ld0, ld1, ld2;
    logic [7:0]  rsh;
    logic [31:0] mag1_d, res2_d;
    logic        ok1_d, inv2_d;

    assign ld2 = !v2_q || O_READY;
    assign ld1 = !v1_q || ld2;
    assign ld0 = !v0_q || ld1;

    assign A_READY   = ld0;
    assign O_VALID   = v2_q;
    assign O         = res2_q;
    assign O_INVALID = inv2_q;

    always_comb begin
        mag1_d = '0;
        rsh    = EXP_LSB_ONE - e0_q;
        if (e0_q >= EXP_LSB_ONE) begin
            // Left shift capped at 8: larger exponents are out of range regardless.
            if (e0_q > EXP_U_MAX) mag1_d = {m0_q, 8'd0};
            else                  mag1_d = {8'd0, m0_q} << (e0_q - EXP_LSB_ONE);
        end else if (rsh < 8'd24) begin
            mag1_d = {8'd0, m0_q} >> rsh;
        end
    end

    always_comb begin
        ok1_d = 1'b0;
        if (cls0_q == F32_TINY) begin
            ok1_d = 1'b1;
        end else if (cls0_q == F32_NORMAL) begin
            if (UNSIGNED) ok1_d = !s0_q && (e0_q <= EXP_U_MAX);
            else          ok1_d = (e0_q <= EXP_S_MAX) ||
                                  (s0_q && e0_q == EXP_U_MAX && m0_q[22:0] == 23'd0);
        end
    end

    always_comb begin
        res2_d = '0;
        inv2_d = 1'b0;
        if (cls1_q == F32_TINY) begin
            res2_d = '0;
        end else if (ok1_q) begin
            res2_d = (!UNSIGNED && s1_q) ? (32'd0 - mag1_q) : mag1_q;
        end else begin
            inv2_d = 1'b1;
`ifdef FPU_F2I_SATURATE_EN
            if (cls1_q == F32_NAN) res2_d = '0;
            else if (!s1_q)        res2_d = UNSIGNED ? UINT32_MAX : INT32_MAX;
            else                   res2_d = UNSIGNED ? 32'd0 : INT32_MIN;
`else
            res2_d = UNSIGNED ? UINT32_MAX : INT32_MIN;
`endif
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            v0_q   <= 1'b0;
            s0_q   <= 1'b0;
            e0_q   <= '0;
            m0_q   <= '0;
            cls0_q <= F32_NORMAL;
            v1_q   <= 1'b0;
            s1_q   <= 1'b0;
            ok1_q  <= 1'b0;
            mag1_q <= '0;
            cls1_q <= F32_NORMAL;
            v2_q   <= 1'b0;
            inv2_q <= 1'b0;
            res2_q <= '0;
        end else begin
            if (ld0) begin
                v0_q <= A_VALID;
                if (A_VALID) begin
                    s0_q   <= un_sign;
                    e0_q   <= un_exp;
                    m0_q   <= un_mant;
                    cls0_q <= un_class;
                end
            end
            if (ld1) begin
                v1_q <= v0_q;
                if (v0_q) begin
                    s1_q   <= s0_q;
                    ok1_q  <= ok1_d;
                    mag1_q <= mag1_d;
                    cls1_q <= cls0_q;
                end
            end
            if (ld2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    res2_q <= res2_d;
                    inv2_q <= inv2_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpu_f32_to_int.sv
// Bench for fpu_f32_to_int: signed and unsigned instances, real-arithmetic reference model and scoreboard.
module tb_fpu_f32_to_int;

`ifdef FPU_F2I_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a    [2];
    logic        av   [2];
    logic        ard  [2];
    logic [31:0] o    [2];
    logic        oinv [2];
    logic        ov   [2];
    logic        ordy [2];

    int errors = 0;
    int checks = 0;
    int n_acc0 = 0;

    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic        prev_stall [2];
    logic [32:0] held       [2];

    always #5 clk = ~clk;

    fpu_f32_to_int #(.UNSIGNED(1'b0)) dut_s (
        .CLK(clk), .nRST(rst_n), .A(a[0]), .A_VALID(av[0]), .A_READY(ard[0]),
        .O(o[0]), .O_INVALID(oinv[0]), .O_VALID(ov[0]), .O_READY(ordy[0])
    );

    fpu_f32_to_int #(.UNSIGNED(1'b1)) dut_u (
        .CLK(clk), .nRST(rst_n), .A(a[1]), .A_VALID(av[1]), .A_READY(ard[1]),
        .O(o[1]), .O_INVALID(oinv[1]), .O_VALID(ov[1]), .O_READY(ordy[1])
    );

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: value of the float as a real, then truncate toward zero and range-check.
    function automatic logic [32:0] model(input logic [31:0] v, input bit uns);
        int          e;
        int          fr;
        real         r;
        longint      q;
        bit          inv, nan, pos;
        logic [31:0] res;
        e   = int'(v[30:23]);
        fr  = int'(v[22:0]);
        q   = 0;
        nan = 1'b0;
        r   = 0.0;
        if (e == 255) begin
            inv = 1'b1;
            nan = (fr != 0);
            pos = !v[31];
        end else begin
            if (e == 0) r = real'(fr) * (2.0 ** (-149));
            else        r = (1.0 + real'(fr) / 8388608.0) * (2.0 ** (e - 127));
            if (v[31]) r = -r;
            pos = (r > 0.0);
            if (uns) inv = !(r > -1.0 && r < 4294967296.0);
            else     inv = !(r >= -2147483648.0 && r < 2147483648.0);
            if (!inv) begin
                q = longint'(r);
                if (r >= 0.0 && real'(q) > r) q = q - 1;
                if (r < 0.0 && real'(q) < r)  q = q + 1;
            end
        end
        if (!inv)      res = q[31:0];
        else if (SAT)  res = nan ? 32'h0 : (pos ? (uns ? 32'hFFFF_FFFF : 32'h7FFF_FFFF)
                                                : (uns ? 32'h0 : 32'h8000_0000));
        else           res = uns ? 32'hFFFF_FFFF : 32'h8000_0000;
        return {inv, res};
    endfunction

    task automatic cmp_one(input int k);
        logic [32:0] act;
        logic [32:0] exp;
        bit          empty;
        act = {oinv[k], o[k]};
        if (prev_stall[k]) begin
            check("hold_valid", {32'd0, ov[k]}, 33'd1);
            if (ov[k]) check("hold_data", act, held[k]);
        end
        if (ov[k] && ordy[k]) begin
            empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
            checks++;
            if (empty) begin
                errors++;
                $display("FAIL spurious_out[%0d]: got %h expected no output", k, act);
            end else begin
                checks--;
                if (k == 0) exp = q0.pop_front();
                else        exp = q1.pop_front();
                check(k == 0 ? "result_s" : "result_u", act, exp);
            end
        end
        prev_stall[k] = ov[k] && !ordy[k];
        held[k]       = act;
        if (av[k] && ard[k]) begin
            if (k == 0) begin
                q0.push_back(model(a[k], 1'b0));
                n_acc0++;
            end else begin
                q1.push_back(model(a[k], 1'b1));
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            prev_stall[0] = 1'b0;
            prev_stall[1] = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) cmp_one(k);
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the operand.
    task automatic send(input int k, input logic [31:0] v);
        bit done;
        done  = 1'b0;
        a[k]  = v;
        av[k] = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (ard[k]) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) check("accept_timeout", 33'd0, 33'd1);
        av[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    localparam int NS = 13;
    localparam int NU = 7;
    logic [31:0] vec_s [NS] = '{32'hCF00_0000, 32'h4F00_0000, 32'h7FC0_0000, 32'h0000_0001,
                                32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h4EFF_FFFF,
                                32'h3F7F_FFFF, 32'hC2F6_E979, 32'h4B00_0001, 32'hCF00_0001,
                                32'hCEFF_FFFF};
    logic [31:0] vec_u [NU] = '{32'h4F80_0000, 32'hBF00_0000, 32'hBF80_0000, 32'h4F7F_FFFF,
                                32'h4F00_0000, 32'h3FC0_0000, 32'h7FC0_0000};
    logic [31:0] vec_bp [5] = '{32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000,
                                32'h4080_0000, 32'h40A0_0000};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_before;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            a[k] = '0; av[k] = 1'b0; ordy[k] = 1'b1;
            prev_stall[k] = 1'b0; held[k] = '0;
        end

        check("pin_1p5",    model(32'h3FC0_0000, 1'b0), {1'b0, 32'h0000_0001});
        check("pin_m3p75",  model(32'hC070_0000, 1'b0), {1'b0, 32'hFFFF_FFFD});
        check("pin_min",    model(32'hCF00_0000, 1'b0), {1'b0, 32'h8000_0000});
        check("pin_2p31",   model(32'h4F00_0000, 1'b0), {1'b1, SAT ? 32'h7FFF_FFFF : 32'h8000_0000});
        check("pin_nan",    model(32'h7FC0_0000, 1'b0), {1'b1, SAT ? 32'h0 : 32'h8000_0000});
        check("pin_u2p32",  model(32'h4F80_0000, 1'b1), {1'b1, 32'hFFFF_FFFF});
        check("pin_um0p5",  model(32'hBF00_0000, 1'b1), {1'b0, 32'h0});
        check("pin_um1",    model(32'hBF80_0000, 1'b1), {1'b1, SAT ? 32'h0 : 32'hFFFF_FFFF});

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_ovalid", {32'd0, ov[k]},   33'd0);
            check("rst_o",      {1'b0, o[k]},     33'd0);
            check("rst_oinv",   {32'd0, oinv[k]}, 33'd0);
            check("rst_aready", {32'd0, ard[k]},  33'd1);
        end
        @(posedge clk);
        #1;

        // Latency: accepts on consecutive edges, results exactly 3 edges later.
        fork
            begin
                send(0, 32'h3FC0_0000);
                send(0, 32'hC070_0000);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1 check("lat_early", {32'd0, ov[0]}, 33'd0);
                @(posedge clk);
                #1 check("lat_first", {ov[0], oinv[0], o[0]} , {1'b1, 1'b0, 32'h0000_0001} );
                @(posedge clk);
                #1 check("lat_second", {ov[0], oinv[0], o[0]}, {1'b1, 1'b0, 32'hFFFF_FFFD});
            end
        join

        for (int i = 0; i < NS; i++) send(0, vec_s[i]);
        for (int i = 0; i < NU; i++) send(1, vec_u[i]);
        idle(6);
        check("drain_s", 33'(q0.size()), 33'd0);
        check("drain_u", 33'(q1.size()), 33'd0);

        // Backpressure: five operands against a stalled sink.
        ordy[0]    = 1'b0;
        acc_before = n_acc0;
        fork
            begin
                for (int i = 0; i < 5; i++) send(0, vec_bp[i]);
            end
            begin
                idle(8);
                check("bp_aready", {32'd0, ard[0]}, 33'd0);
                check("bp_accepts", 33'(n_acc0 - acc_before), 33'd3);
                ordy[0] = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_rate", {32'd0, ov[0]}, 33'd1);
                end
            end
        join
        idle(6);
        check("bp_drain", 33'(q0.size()), 33'd0);
        check("bp_total", 33'(n_acc0 - acc_before), 33'd5);

        // Asynchronous reset with two items in flight.
        ordy[0] = 1'b0;
        send(0, 32'h3FC0_0000);
        send(0, 32'h4000_0000);
        @(posedge clk);
        #1 check("mid_ovalid_pre", {ov[0], o[0]}, {1'b1, 32'h0000_0001});
        #2 rst_n = 1'b0;
        #1;
        check("mid_ovalid", {32'd0, ov[0]}, 33'd0);
        check("mid_o",      {1'b0, o[0]},   33'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        ordy[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("mid_stale", {32'd0, ov[0]}, 33'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
